// File: rtl/l3_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : l3_arb_pkg                                                 |
// | Brief   : Shared types, default widths and helpers for l3_arbiter.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package l3_arb_pkg;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Index width for NUM_REQ requesters; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l3_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : l3_arbiter_if                                              |
// | Brief   : Requester-side and L3-side buses of the L3 port arbiter.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface l3_arbiter_if
    import l3_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_done;
    logic [DATA_W-1:0]         req_rdata;
    logic                      req_err;

    logic                      down_req;
    logic                      down_we;
    logic [ADDR_W-1:0]         down_addr;
    logic [DATA_W-1:0]         down_wdata;
    logic [DATA_W-1:0]         down_rdata;
    logic                      down_done;

    // The arbiter side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, down_rdata, down_done,
        output req_done, req_rdata, req_err, down_req, down_we, down_addr, down_wdata
    );

    // Requesters plus the L3 model.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, down_rdata, down_done,
        input  req_done, req_rdata, req_err, down_req, down_we, down_addr, down_wdata
    );
endinterface
`default_nettype wire

// File: rtl/l3_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_pick                                                    |
// | Brief   : Combinational round-robin picker, searches from last+1.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_pick
    import l3_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int GW      = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last,
    output logic [NUM_REQ-1:0] grant,
    output logic [GW-1:0]      grant_idx,
    output logic               any_valid
);
    logic [GW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_cand    = '0;
        w_found   = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = GW'((int'(last) + off) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found         = 1'b1;
                grant_idx       = w_cand;
                grant[w_cand]   = 1'b1;
            end
        end
    end

    assign any_valid = |req;

endmodule
`default_nettype wire

// File: rtl/l3_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : l3_arbiter                                                 |
// | Brief   : Round-robin arbiter for the single L3 port, with watchdog. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module l3_arbiter
    import l3_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int GW            = grant_w(NUM_REQ)
) (
    input  logic          clk,
    input  logic          reset,
    l3_arbiter_if.slave   bus,
    output logic          busy,
    output logic [GW-1:0] grant_id,
    output logic          timeout_flag
);
    localparam int              WD_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]   LAST_INIT = GW'(NUM_REQ - 1);

    arb_state_t          r_state;
    arb_state_t          w_next;
    logic [GW-1:0]       r_last;
    logic [GW-1:0]       r_grant;
    logic [WD_W-1:0]     r_wdog;
    logic                r_down_req;
    logic                r_down_we;
    logic [ADDR_W-1:0]   r_down_addr;
    logic [DATA_W-1:0]   r_down_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_tflag;

    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [GW-1:0]       w_pick_idx;
    logic                w_any;
    logic                w_expire;
    logic [NUM_REQ-1:0]  w_done;
    logic                w_err;

    logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_pick (
        .req       (bus.req_valid),
        .last      (r_last),
        .grant     (w_pick_onehot),
        .grant_idx (w_pick_idx),
        .any_valid (w_any)
    );

    assign w_expire = (r_wdog == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = WAIT;
            WAIT:    if (bus.down_done || w_expire) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state != IDLE);
        w_done = '0;
        if (r_state == RESP) w_done[r_grant] = 1'b1;
        w_err  = (r_state == RESP) && r_err;
    end

    // Request capture happens only in IDLE, so requester-side changes later
    // cannot disturb the transaction already on the L3 port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last       <= LAST_INIT;
            r_grant      <= '0;
            r_wdog       <= '0;
            r_down_req   <= 1'b0;
            r_down_we    <= 1'b0;
            r_down_addr  <= '0;
            r_down_wdata <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_tflag      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_pick_idx;
                        r_down_req   <= 1'b1;
                        r_down_we    <= |(bus.req_we & w_pick_onehot);
                        r_down_addr  <= w_addr_arr[w_pick_idx];
                        r_down_wdata <= w_wdata_arr[w_pick_idx];
                        r_wdog       <= '0;
                        r_err        <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.down_done) begin
                        r_rdata    <= r_down_we ? '0 : bus.down_rdata;
                        r_down_req <= 1'b0;
                    end else if (w_expire) begin
                        r_rdata    <= '0;
                        r_down_req <= 1'b0;
                        r_err      <= 1'b1;
                        r_tflag    <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                RESP: r_last <= r_grant;
                default: ;
            endcase
        end
    end

    assign bus.down_req   = r_down_req;
    assign bus.down_we    = r_down_we;
    assign bus.down_addr  = r_down_addr;
    assign bus.down_wdata = r_down_wdata;
    assign bus.req_done   = w_done;
    assign bus.req_rdata  = r_rdata;
    assign bus.req_err    = w_err;
    assign grant_id       = r_grant;
    assign timeout_flag   = r_tflag;

endmodule
`default_nettype wire

// File: tb/tb_l3_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_l3_arbiter                                              |
// | Brief   : Directed vector bench for l3_arbiter (2 requesters, T=8).  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_l3_arbiter;

    logic       clk;
    logic       reset;
    logic       busy;
    logic [0:0] grant_id;
    logic       timeout_flag;

    int n_total = 0;
    int n_pass  = 0;
    int cnt0    = 0;
    int cnt1    = 0;

    l3_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

    l3_arbiter #(
        .NUM_REQ        (2),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_flag (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
        logic [31:0] rdata;
        int          delay;
        logic        exp_grant;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_done;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic wait_down_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.down_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("down_req_seen", 64'(bus.down_req), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        bus.req_valid = v.valid;
        bus.req_we    = v.we;
        bus.req_addr  = {v.addr1, v.addr0};
        bus.req_wdata = {v.wdata1, v.wdata0};
        wait_down_req(ok);
        if (!ok) begin
            bus.req_valid = '0;
            return;
        end
        check("grant_id",   64'(grant_id),       64'(v.exp_grant));
        check("down_addr",  64'(bus.down_addr),  64'(v.exp_addr));
        check("down_we",    64'(bus.down_we),    64'(v.exp_we));
        check("down_wdata", 64'(bus.down_wdata), 64'(v.exp_wdata));
        for (int d = 0; d < v.delay; d++) begin
            @(negedge clk);
            check("wait_down_req", 64'(bus.down_req), 64'd1);
            check("wait_stable", {bus.down_addr, bus.down_wdata},
                  {v.exp_addr, v.exp_wdata});
        end
        bus.down_done  = 1'b1;
        bus.down_rdata = v.rdata;
        @(negedge clk);
        bus.down_done  = 1'b0;
        bus.down_rdata = '0;
        check("req_done",      64'(bus.req_done),  64'(v.exp_done));
        check("req_rdata",     64'(bus.req_rdata), 64'(v.exp_rdata));
        check("req_err",       64'(bus.req_err),   64'd0);
        check("resp_down_req", 64'(bus.down_req),  64'd0);
        if (bus.req_done[0]) cnt0++;
        if (bus.req_done[1]) cnt1++;
        @(negedge clk);
        check("done_one_cycle", 64'(bus.req_done), 64'd0);
        check("idle_busy",      64'(busy),         64'd0);
        bus.req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        bit ok;
        int wcycles;

        vecs[0] = '{2'b01, 2'b00, 32'h0000_1040, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 3,
                    1'b0, 32'h0000_1040, 1'b0, 32'h0, 32'hDEAD_BEEF, 2'b01};
        vecs[1] = '{2'b10, 2'b10, 32'h0, 32'h0000_2000, 32'h0, 32'h1234_5678, 32'hFFFF_0000, 2,
                    1'b1, 32'h0000_2000, 1'b1, 32'h1234_5678, 32'h0, 2'b10};
        vecs[2] = '{2'b11, 2'b00, 32'h0000_A000, 32'h0000_B000, 32'h1111_1111, 32'h2222_2222,
                    32'h0000_A0A0, 1, 1'b0, 32'h0000_A000, 1'b0, 32'h1111_1111, 32'h0000_A0A0, 2'b01};
        vecs[3] = '{2'b11, 2'b00, 32'h0000_A000, 32'h0000_B000, 32'h1111_1111, 32'h2222_2222,
                    32'h0000_B0B0, 1, 1'b1, 32'h0000_B000, 1'b0, 32'h2222_2222, 32'h0000_B0B0, 2'b10};
        vecs[4] = '{2'b11, 2'b00, 32'h0000_A000, 32'h0000_B000, 32'h1111_1111, 32'h2222_2222,
                    32'h0000_C0C0, 1, 1'b0, 32'h0000_A000, 1'b0, 32'h1111_1111, 32'h0000_C0C0, 2'b01};
        vecs[5] = '{2'b11, 2'b00, 32'h0000_A000, 32'h0000_B000, 32'h1111_1111, 32'h2222_2222,
                    32'h0000_D0D0, 1, 1'b1, 32'h0000_B000, 1'b0, 32'h2222_2222, 32'h0000_D0D0, 2'b10};

        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.down_rdata = '0;
        bus.down_done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_down_req",  64'(bus.down_req),  64'd0);
        check("rst_busy",      64'(busy),          64'd0);
        check("rst_req_done",  64'(bus.req_done),  64'd0);
        check("rst_grant_id",  64'(grant_id),      64'd0);
        check("rst_tflag",     64'(timeout_flag),  64'd0);
        check("rst_req_err",   64'(bus.req_err),   64'd0);
        check("rst_req_rdata", 64'(bus.req_rdata), 64'd0);
        reset = 1'b0;

        // Stray completion with nothing in flight.
        @(negedge clk);
        bus.down_done  = 1'b1;
        bus.down_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        bus.down_done  = 1'b0;
        bus.down_rdata = '0;
        check("spur_req_done",  64'(bus.req_done), 64'd0);
        check("spur_busy",      64'(busy),         64'd0);
        @(negedge clk);
        check("spur_req_done2", 64'(bus.req_done), 64'd0);
        check("spur_down_req",  64'(bus.down_req), 64'd0);

        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                cnt0 = 0;
                cnt1 = 0;
            end
            run_vec(vecs[i]);
        end
        check("rr_count_req0", 64'(cnt0), 64'd2);
        check("rr_count_req1", 64'(cnt1), 64'd2);

        // Watchdog abort: L3 never answers.
        check("tflag_before", 64'(timeout_flag), 64'd0);
        bus.req_valid = 2'b01;
        bus.req_we    = 2'b00;
        bus.req_addr  = {32'h0, 32'h0000_3000};
        wait_down_req(ok);
        wcycles = 0;
        if (ok) begin
            wcycles = 1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!bus.down_req) break;
                wcycles++;
            end
        end
        check("to_wait_cycles", 64'(wcycles),       64'd8);
        check("to_req_done",    64'(bus.req_done),  64'd1);
        check("to_req_err",     64'(bus.req_err),   64'd1);
        check("to_req_rdata",   64'(bus.req_rdata), 64'd0);
        check("to_tflag",       64'(timeout_flag),  64'd1);
        bus.req_valid = '0;
        @(negedge clk);
        check("to_done_clear",  64'(bus.req_done),  64'd0);
        check("to_err_clear",   64'(bus.req_err),   64'd0);
        @(negedge clk);
        check("to_tflag_sticky", 64'(timeout_flag), 64'd1);

        // Reset in the middle of a transaction, then re-grant of req1.
        bus.req_valid = 2'b10;
        bus.req_addr  = {32'h0000_4000, 32'h0};
        wait_down_req(ok);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst_down_req", 64'(bus.down_req), 64'd0);
        check("mrst_busy",     64'(busy),         64'd0);
        check("mrst_tflag",    64'(timeout_flag), 64'd0);
        @(negedge clk);
        check("mrst_no_done",  64'(bus.req_done), 64'd0);
        reset = 1'b0;
        wait_down_req(ok);
        if (ok) begin
            check("mrst_regrant", 64'(grant_id),      64'd1);
            check("mrst_addr",    64'(bus.down_addr), 64'h4000);
            bus.down_done  = 1'b1;
            bus.down_rdata = 32'h0000_55AA;
            @(negedge clk);
            bus.down_done  = 1'b0;
            check("mrst_req_done", 64'(bus.req_done),  64'd2);
            check("mrst_rdata",    64'(bus.req_rdata), 64'h55AA);
        end
        bus.req_valid = '0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
